// File: rtl/inst_fetch_pipe.sv
// Instruction fetch: PC generation, 1-cycle synchronous imem request, IF/ID queue; imem_en to instr_valid is 2 cycles.
// Backpressure: a fetch issues only while queue slots (after this cycle's pop) cover every in-flight response.
module inst_fetch_pipe #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        Q_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_code,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] code;
  } if_entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  if_entry_t         r_q [Q_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic              w_redir;
  logic              w_valid;
  logic              w_pop;
  logic              w_land;
  logic              w_issue;
  logic [OW-1:0]     w_occ;
  logic [ADDR_W-1:0] w_br_pc;
  logic [ADDR_W-1:0] w_jmp_pc;
  if_entry_t         w_head;

  assign w_valid  = (r_count != '0);
  assign w_redir  = branch_taken | jump;
  assign w_pop    = w_valid & instr_ready & ~w_redir & ~reset;
  assign w_land   = r_inflight & ~w_redir & ~reset;
  // Occupancy net of this cycle's pop lets a full-rate stream sustain one fetch per cycle.
  assign w_occ    = {1'b0, r_count} - OW'(w_pop) + OW'(r_inflight);
  assign w_issue  = ~reset & ~halt & ~w_redir & (w_occ < OW'(Q_DEPTH));
  assign w_br_pc  = branch_target & ~ADDR_W'(3);
  assign w_jmp_pc = {r_pc[ADDR_W-1:28], jump_index, 2'b00};
  assign w_head   = r_q[r_rd_ptr];

  assign imem_en     = w_issue;
  assign imem_addr   = r_pc;
  assign instr_valid = w_valid;
  assign instr_code  = w_valid ? w_head.code : '0;
  assign instr_pc    = w_valid ? w_head.pc   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
    end else if (w_redir) begin
      r_pc       <= branch_taken ? w_br_pc : w_jmp_pc;
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_pc          <= r_pc + ADDR_W'(4);
        r_inflight_pc <= r_pc;
      end
      r_inflight <= w_issue;
      if (w_land) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_land) - CW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_land) r_q[r_wr_ptr] <= '{pc: r_inflight_pc, code: imem_rdata};
  end

endmodule

// File: tb/tb_inst_fetch_pipe.sv
// Bench for inst_fetch_pipe: directed scenarios plus random traffic against a queue-based reference model.
module tb_inst_fetch_pipe;
  localparam int QD = 2;
  localparam logic [31:0] RPC = 32'h100;

  logic        clk = 1'b0;
  logic        reset, halt, jump, branch_taken, instr_ready;
  logic [25:0] jump_index;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_en, instr_valid;
  logic [31:0] imem_addr, instr_code, instr_pc;

  always #5 clk = ~clk;

  inst_fetch_pipe #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC), .Q_DEPTH(QD)) dut (
    .clk(clk), .reset(reset), .halt(halt), .jump(jump), .jump_index(jump_index),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_code(instr_code), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] code; } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_infl;
  logic [31:0] m_infl_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic        obs_en, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_code;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] code_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit rst, input bit hlt, input bit jmp, input logic [25:0] idx,
                      input bit br, input logic [31:0] tgt, input bit rdy);
    bit   redir, pop, exp_en;
    int   occ;
    ent_t e;
    @(negedge clk);
    reset = rst; halt = hlt; jump = jmp; jump_index = idx;
    branch_taken = br; branch_target = tgt; instr_ready = rdy;
    imem_rdata = m_infl ? code_of(m_infl_pc) : $urandom;
    #1;
    redir  = br | jmp;
    pop    = !rst && !redir && rdy && (m_q.size() > 0);
    occ    = m_q.size() - (pop ? 1 : 0) + (m_infl ? 1 : 0);
    exp_en = !rst && !hlt && !redir && (occ < QD);
    obs_en = imem_en; obs_addr = imem_addr; obs_valid = instr_valid;
    obs_pc = instr_pc; obs_code = instr_code;
    chk("imem_en", imem_en, exp_en);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_q.size() > 0);
    chk("instr_pc", instr_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
    chk("instr_code", instr_code, (m_q.size() > 0) ? m_q[0].code : 32'h0);
    if (rst) begin
      m_pc = RPC; m_q.delete(); m_infl = 0;
    end else if (redir) begin
      m_pc = br ? {tgt[31:2], 2'b00} : {m_pc[31:28], idx, 2'b00};
      m_q.delete(); m_infl = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) begin
        e.pc = m_infl_pc; e.code = imem_rdata;
        m_q.push_back(e);
      end
      m_infl = exp_en;
      if (exp_en) begin
        m_infl_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 26'h0, 0, 32'h0, rdy);
  endtask

  initial begin
    int n_en;
    reset = 1; halt = 0; jump = 0; jump_index = '0; branch_taken = 0;
    branch_target = '0; instr_ready = 0; imem_rdata = '0;
    @(posedge clk);
    m_pc = RPC; m_q.delete(); m_infl = 0; m_infl_pc = '0;

    // Reset then first fetches from RESET_PC
    for (int i = 0; i < 3; i++) step(1, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t1_rst_en", obs_en, 1'b0);
    chk("t1_rst_valid", obs_valid, 1'b0);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t1_first_addr", obs_addr, 32'h100);
    chk("t1_first_en", obs_en, 1'b1);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t1_second_addr", obs_addr, 32'h104);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t1_head_valid", obs_valid, 1'b1);
    chk("t1_head_pc", obs_pc, 32'h100);
    chk("t1_stream_addr", obs_addr, 32'h108);

    // Stall with ready low: only Q_DEPTH fetches, then drain in order
    step(1, 0, 0, 26'h0, 0, 32'h0, 0);
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 26'h0, 0, 32'h0, 0);
      n_en += obs_en;
    end
    chk("t2_fetch_count", n_en, QD);
    chk("t2_hold_pc", obs_pc, 32'h100);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t2_drain0", obs_pc, 32'h100);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t2_drain1", obs_pc, 32'h104);
    run(4, 1);

    // Pseudo-direct jump from 0x1000_0020 with queue and in-flight populated
    run(2, 0);
    step(0, 1, 0, 26'h0, 1, 32'h1000_0020, 0);
    step(0, 1, 1, 26'h40, 0, 32'h0, 0);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t3_jump_addr", obs_addr, 32'h1000_0100);
    chk("t3_flushed", obs_valid, 1'b0);
    run(5, 1);

    // Branch beats jump in the same cycle
    step(0, 0, 1, 26'h3FF_FFFF, 1, 32'h203, 1);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t4_branch_wins", obs_addr, 32'h200);
    run(3, 1);

    // Halt with full queue, redirect, hold, then wrap past the top of memory
    run(3, 0);
    step(0, 1, 0, 26'h0, 1, 32'hFFFF_FFFC, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 26'h0, 0, 32'h0, 0);
      chk("t5_halt_en", obs_en, 1'b0);
      chk("t5_halt_addr", obs_addr, 32'hFFFF_FFFC);
    end
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t5_resume_en", obs_en, 1'b1);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t5_wrap_addr", obs_addr, 32'h0);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t5_wrap_head", obs_pc, 32'hFFFF_FFFC);

    // Reset with in-flight fetch and non-empty queue
    run(2, 0);
    run(2, 0);
    step(1, 0, 0, 26'h0, 0, 32'h0, 0);
    step(0, 0, 0, 26'h0, 0, 32'h0, 1);
    chk("t6_empty", obs_valid, 1'b0);
    chk("t6_restart", obs_addr, RPC);
    run(6, 1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0, 26'($urandom),
           $urandom_range(0, 15) == 0, $urandom,
           $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
